// File: rtl/pacman_pkg.sv
// Shared direction/keycode types and the direction-to-step helper for sprite motion logic.
package pacman_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVING,
        ST_TURN_PEND
    } rx_state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } step_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    // Screen Y grows downward, so UP is a negative Y step.
    function automatic step_t dir_to_step(input dir_t d, input logic [3:0] speed);
        step_t      s;
        logic [9:0] mag;
        mag = {6'd0, speed};
        s   = '0;
        case (d)
            DIR_UP:    s.y = '0 - mag;
            DIR_DOWN:  s.y = mag;
            DIR_LEFT:  s.x = '0 - mag;
            DIR_RIGHT: s.x = mag;
            default:   s   = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dir_cmd_receiver_frame_tick_sync.sv
// Brings the asynchronous frame clock into the Clk domain and emits a one-cycle tick per rising edge.
module frame_tick_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_async,
    output logic o_tick
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_tick = r_s2 & ~r_s3;

endmodule

// File: rtl/dir_cmd_receiver.sv
// Direction command receiver: buffers a requested turn until the wall masks allow it,
// then commits the direction and emits a per-frame step vector with a move strobe.
module dir_cmd_receiver
    import pacman_pkg::*;
#(
    parameter int unsigned SPEED       = 1,
    parameter int unsigned PEND_FRAMES = 8,
    parameter logic [7:0]  KC_UP       = KEY_W,
    parameter logic [7:0]  KC_LEFT     = KEY_A,
    parameter logic [7:0]  KC_DOWN     = KEY_S,
    parameter logic [7:0]  KC_RIGHT    = KEY_D
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       restart,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [4:0] mapL,
    input  logic [4:0] mapR,
    input  logic [4:0] mapT,
    input  logic [4:0] mapB,
    output logic [2:0] dir_out,
    output logic [9:0] step_x,
    output logic [9:0] step_y,
    output logic       move_pulse,
    output logic       pending_valid,
    output logic [2:0] pending_dir
);

    rx_state_t  r_state, w_state_nxt;
    dir_t       r_dir, w_dir_nxt;
    dir_t       r_pdir, w_pdir_nxt;
    dir_t       w_req;
    logic [7:0] r_timer, w_timer_nxt;
    logic [9:0] r_step_x, w_step_x_nxt;
    logic [9:0] r_step_y, w_step_y_nxt;
    logic       r_pulse, w_pulse_nxt;
    logic       w_pv, w_pv_nxt;
    logic       w_tick;
    step_t      w_step;

    frame_tick_sync u_tick_sync (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_clr   (restart),
        .i_async (frame_clk),
        .o_tick  (w_tick)
    );

    function automatic logic side_blocked(input dir_t d);
        case (d)
            DIR_UP:    return |mapT;
            DIR_DOWN:  return |mapB;
            DIR_LEFT:  return |mapL;
            DIR_RIGHT: return |mapR;
            default:   return 1'b0;
        endcase
    endfunction

    always_comb begin
        w_req = DIR_NONE;
        if (keycode == KC_UP)         w_req = DIR_UP;
        else if (keycode == KC_DOWN)  w_req = DIR_DOWN;
        else if (keycode == KC_LEFT)  w_req = DIR_LEFT;
        else if (keycode == KC_RIGHT) w_req = DIR_RIGHT;
    end

    assign w_pv = (r_state == ST_TURN_PEND);

    always_comb begin
        w_dir_nxt    = r_dir;
        w_pdir_nxt   = r_pdir;
        w_pv_nxt     = w_pv;
        w_timer_nxt  = r_timer;
        w_step_x_nxt = r_step_x;
        w_step_y_nxt = r_step_y;
        w_pulse_nxt  = 1'b0;
        w_state_nxt  = r_state;
        w_step       = '0;

        if (w_tick) begin
            if (w_pv && !side_blocked(r_pdir)) begin
                w_dir_nxt   = r_pdir;
                w_pv_nxt    = 1'b0;
                w_pdir_nxt  = DIR_NONE;
                w_timer_nxt = '0;
            end else if (r_dir != DIR_NONE && side_blocked(r_dir)) begin
                w_dir_nxt = DIR_NONE;
            end else if (w_pv) begin
                if (r_timer == 8'd1) begin
                    w_pv_nxt    = 1'b0;
                    w_pdir_nxt  = DIR_NONE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            w_step       = dir_to_step(w_dir_nxt, 4'(SPEED));
            w_step_x_nxt = w_step.x;
            w_step_y_nxt = w_step.y;
            w_pulse_nxt  = (w_dir_nxt != DIR_NONE);
        end

        // Capture is compared against the post-tick direction and overrides the tick's pending update.
        if (w_req != DIR_NONE) begin
            if (w_req != w_dir_nxt) begin
                w_pv_nxt    = 1'b1;
                w_pdir_nxt  = w_req;
                w_timer_nxt = 8'(PEND_FRAMES);
            end else begin
                w_pv_nxt    = 1'b0;
                w_pdir_nxt  = DIR_NONE;
                w_timer_nxt = '0;
            end
        end

        if (w_pv_nxt)                   w_state_nxt = ST_TURN_PEND;
        else if (w_dir_nxt != DIR_NONE) w_state_nxt = ST_MOVING;
        else                            w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge Clk) begin
        if (!Reset || restart) begin
            r_state  <= ST_IDLE;
            r_dir    <= DIR_NONE;
            r_pdir   <= DIR_NONE;
            r_timer  <= '0;
            r_step_x <= '0;
            r_step_y <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_pdir   <= w_pdir_nxt;
            r_timer  <= w_timer_nxt;
            r_step_x <= w_step_x_nxt;
            r_step_y <= w_step_y_nxt;
            r_pulse  <= w_pulse_nxt;
        end
    end

    assign dir_out       = r_dir;
    assign step_x        = r_step_x;
    assign step_y        = r_step_y;
    assign move_pulse    = r_pulse;
    assign pending_valid = (r_state == ST_TURN_PEND);
    assign pending_dir   = r_pdir;

endmodule

// File: tb/tb_dir_cmd_receiver.sv
// Bench for dir_cmd_receiver: directed scenarios plus randomized traffic against a behavioural model.
module tb_dir_cmd_receiver;

    localparam int SPEED = 1;
    localparam int PEND  = 8;

    logic       Clk = 1'b0;
    logic       Reset, restart, frame_clk;
    logic [7:0] keycode;
    logic [4:0] mapL, mapR, mapT, mapB;
    logic [2:0] dir_out, pending_dir;
    logic [9:0] step_x, step_y;
    logic       move_pulse, pending_valid;

    int n_cmp = 0;
    int n_bad = 0;

    dir_cmd_receiver #(
        .SPEED       (SPEED),
        .PEND_FRAMES (PEND),
        .KC_UP       (8'h1A),
        .KC_LEFT     (8'h04),
        .KC_DOWN     (8'h16),
        .KC_RIGHT    (8'h07)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .restart       (restart),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .mapL          (mapL),
        .mapR          (mapR),
        .mapT          (mapT),
        .mapB          (mapB),
        .dir_out       (dir_out),
        .step_x        (step_x),
        .step_y        (step_y),
        .move_pulse    (move_pulse),
        .pending_valid (pending_valid),
        .pending_dir   (pending_dir)
    );

    always #5 Clk = ~Clk;

    // Model state: directions as plain ints 0..4, pending 0 means none.
    int m_dir = 0, m_pend = 0, m_timer = 0, m_sx = 0, m_sy = 0;
    bit m_pulse = 0;
    bit smp[$] = '{1'b0, 1'b0, 1'b0};   // frame_clk samples: [0]=3 edges ago, [2]=previous edge

    function automatic int decode(input logic [7:0] k);
        case (k)
            8'h1A:   return 1;
            8'h16:   return 2;
            8'h04:   return 3;
            8'h07:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit side_free(input int d);
        case (d)
            1:       return mapT == 5'd0;
            2:       return mapB == 5'd0;
            3:       return mapL == 5'd0;
            4:       return mapR == 5'd0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_edge();
        int req, nd;
        bit tk;
        if (!Reset || restart) begin
            m_dir = 0; m_pend = 0; m_timer = 0; m_sx = 0; m_sy = 0; m_pulse = 0;
            smp = '{1'b0, 1'b0, 1'b0};
            return;
        end
        tk = smp[1] && !smp[0];
        m_pulse = 0;
        nd = m_dir;
        if (tk) begin
            if (m_pend != 0 && side_free(m_pend)) begin
                nd = m_pend;
                m_pend = 0;
            end else if (m_dir != 0 && !side_free(m_dir)) begin
                nd = 0;
            end else if (m_pend != 0) begin
                m_timer = m_timer - 1;
                if (m_timer == 0) m_pend = 0;
            end
            m_sx = (nd == 4) ? SPEED : (nd == 3) ? -SPEED : 0;
            m_sy = (nd == 2) ? SPEED : (nd == 1) ? -SPEED : 0;
            m_pulse = (nd != 0);
        end
        m_dir = nd;
        req = decode(keycode);
        if (req != 0) begin
            if (req != nd) begin
                m_pend  = req;
                m_timer = PEND;
            end else begin
                m_pend = 0;
            end
        end
        smp.push_back(frame_clk);
        void'(smp.pop_front());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [9:0] ex, ey;
        ex = 10'(m_sx);
        ey = 10'(m_sy);
        chk("m_dir",  32'(dir_out),       32'(m_dir));
        chk("m_sx",   32'(step_x),        32'(ex));
        chk("m_sy",   32'(step_y),        32'(ey));
        chk("m_mp",   32'(move_pulse),    32'(m_pulse));
        chk("m_pv",   32'(pending_valid), 32'(m_pend != 0));
        chk("m_pdir", 32'(pending_dir),   32'(m_pend));
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_frame(output bit saw);
        saw = 1'b0;
        frame_clk = 1'b1;
        repeat (4) begin cyc(); if (move_pulse) saw = 1'b1; end
        frame_clk = 1'b0;
        repeat (4) begin cyc(); if (move_pulse) saw = 1'b1; end
    endtask

    initial begin
        bit saw;
        logic [7:0] keys[7];
        keys = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h00, 8'h55};

        // Reset held with a key and a frame pulse present.
        Reset = 1'b0; restart = 1'b0; frame_clk = 1'b1; keycode = 8'h07;
        mapL = '0; mapR = '0; mapT = '0; mapB = '0;
        cyc(); cyc();
        chk("rst_dir",  32'(dir_out), 32'd0);
        chk("rst_sx",   32'(step_x), 32'd0);
        chk("rst_sy",   32'(step_y), 32'd0);
        chk("rst_mp",   32'(move_pulse), 32'd0);
        chk("rst_pv",   32'(pending_valid), 32'd0);
        chk("rst_pdir", 32'(pending_dir), 32'd0);
        frame_clk = 1'b0;
        cyc();
        Reset = 1'b1;
        repeat (3) cyc();

        // First move: strobe appears on the third edge after frame_clk is sampled high.
        frame_clk = 1'b1;
        cyc(); chk("lat_e1", 32'(move_pulse), 32'd0);
        cyc(); chk("lat_e2", 32'(move_pulse), 32'd0);
        cyc();
        chk("lat_e3", 32'(move_pulse), 32'd1);
        chk("lat_dir", 32'(dir_out), 32'd4);
        chk("lat_sx", 32'(step_x), 32'd1);
        chk("lat_sy", 32'(step_y), 32'd0);
        cyc(); chk("lat_e4", 32'(move_pulse), 32'd0);
        keycode = 8'h00; frame_clk = 1'b0;
        repeat (4) cyc();

        // Blocked UP request is buffered while RIGHT continues.
        mapT = 5'b00100; keycode = 8'h1A;
        cyc();
        keycode = 8'h00;
        chk("pend_pv", 32'(pending_valid), 32'd1);
        chk("pend_pdir", 32'(pending_dir), 32'd1);
        for (int i = 0; i < 3; i++) begin
            run_frame(saw);
            chk("pend_keep", 32'(dir_out), 32'd4);
            chk("pend_still", 32'(pending_valid), 32'd1);
        end
        mapT = 5'd0;
        run_frame(saw);
        chk("turn_dir", 32'(dir_out), 32'd1);
        chk("turn_sy", 32'(step_y), 32'h3FF);
        chk("turn_sx", 32'(step_x), 32'd0);
        chk("turn_pv", 32'(pending_valid), 32'd0);

        // Wall ahead stops motion.
        keycode = 8'h07; cyc(); keycode = 8'h00;
        run_frame(saw);
        chk("right_dir", 32'(dir_out), 32'd4);
        mapR = 5'b00001;
        run_frame(saw);
        chk("stop_pulse", 32'(saw), 32'd0);
        chk("stop_dir", 32'(dir_out), 32'd0);
        chk("stop_sx", 32'(step_x), 32'd0);
        chk("stop_sy", 32'(step_y), 32'd0);

        // Pending request expires on the PEND-th tick.
        mapT = 5'b10000; keycode = 8'h1A; cyc(); keycode = 8'h00;
        for (int i = 1; i <= PEND; i++) begin
            run_frame(saw);
            chk("expire_pv", 32'(pending_valid), (i < PEND) ? 32'd1 : 32'd0);
            chk("expire_dir", 32'(dir_out), 32'd0);
        end

        // restart coincident with a tick that would commit a free pending UP.
        mapT = 5'd0; keycode = 8'h1A; cyc(); keycode = 8'h00;
        chk("rs_pv_pre", 32'(pending_valid), 32'd1);
        frame_clk = 1'b1;
        cyc(); cyc();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("rs_dir", 32'(dir_out), 32'd0);
        chk("rs_pv", 32'(pending_valid), 32'd0);
        chk("rs_mp", 32'(move_pulse), 32'd0);
        saw = 1'b0;
        repeat (3) begin cyc(); if (move_pulse) saw = 1'b1; end
        frame_clk = 1'b0;
        repeat (4) begin cyc(); if (move_pulse) saw = 1'b1; end
        chk("rs_nomove", 32'(saw), 32'd0);
        mapR = 5'd0;

        // Randomized traffic against the model.
        for (int f = 0; f < 250; f++) begin
            int hi, lo;
            mapL = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            mapR = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            mapT = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            mapB = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            hi = $urandom_range(3, 6);
            lo = $urandom_range(3, 6);
            for (int c = 0; c < hi + lo; c++) begin
                frame_clk = (c < hi);
                if ($urandom_range(0, 2) == 0) keycode = keys[$urandom_range(0, 6)];
                restart = ($urandom_range(0, 59) == 0);
                Reset   = ($urandom_range(0, 199) != 0);
                cyc();
            end
            restart = 1'b0;
            Reset = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dir_cmd_receiver.md
Name: dir_cmd_receiver

Overview:
- Consumer end of the direction-command path: accepts keycodes from the USB keyboard (player) or from random_dir (ghost AI).
- Holds a buffered "pending turn" until the wall masks permit it, then commits the direction.
- Emits one per-frame step vector and a move strobe that ball/redghost position registers apply.
- Sits between the keycode source and the sprite motion logic, clocked by Clk, paced by frame_clk (VGA_VS).

Parameters:
- SPEED, 1, pixels moved per frame, magnitude of step_x/step_y (1..15).
- PEND_FRAMES, 8, frames a pending turn survives before being discarded (1..255).
- KC_UP, 8'h1A, keycode for up (W).
- KC_LEFT, 8'h04, keycode for left (A).
- KC_DOWN, 8'h16, keycode for down (S).
- KC_RIGHT, 8'h07, keycode for right (D).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-low reset.
- restart  in  1  synchronous clear, same effect as reset (level/round restart).
- frame_clk  in  1  VGA_VS, asynchronous to Clk; rising edge = frame tick.
- keycode  in  8  command keycode, level; 0 or unrecognised = no request.
- mapL, mapR, mapT, mapB  in  5 each  wall proximity masks; nonzero = that side blocked.
- dir_out  out  3  committed direction: 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT.
- step_x  out  10  two's-complement X step for this frame.
- step_y  out  10  two's-complement Y step for this frame.
- move_pulse  out  1  one-Clk strobe: apply step this frame.
- pending_valid  out  1  a turn request is buffered.
- pending_dir  out  3  buffered direction (NONE when invalid).

Behaviour:
- Reset==0 or restart==1 at a Clk edge clears all state: dir_out=NONE, step_x=step_y=0, move_pulse=0, pending_valid=0, pending_dir=NONE, timer=0, sync flops=0. Reset/restart beats every other event in the same cycle.
- Frame tick: frame_clk passes through 2 sync flops plus a third history flop; tick = s2 & ~s3.
  - tick is high for exactly one Clk, on the 2nd edge after frame_clk is first sampled high.
  - Registered outputs update on the following edge, so move_pulse rises 3 Clk edges after the first sampling edge.
- Decode: KC_UP/KC_DOWN/KC_LEFT/KC_RIGHT map to the corresponding direction. Any other keycode, including 0, makes no request.
- Capture, evaluated every Clk edge (req = decoded keycode):
  - req != NONE and req != dir_next: pending_dir<=req, pending_valid<=1, timer<=PEND_FRAMES.
  - req == dir_next: pending cleared.
  - dir_next is the direction after this cycle's tick evaluation.
  - Capture wins over the tick's pending clear/decrement in the same cycle.
- Side check: UP uses mapT, DOWN uses mapB, LEFT uses mapL, RIGHT uses mapR. "Free" means the mask is 0.
- Tick evaluation, in priority order, using pre-cycle pending:
  1. pending_valid and its side is free: dir<=pending_dir; pending cleared.
  2. Else, dir != NONE and its side is blocked: dir<=NONE (stop); pending retained.
  3. Else dir unchanged. If pending_valid: timer decrements; a tick that sees timer==1 clears pending.
- A reverse (opposite) request follows the same rules; no special case.
- Outputs are registered on the cycle after tick:
  - step from the new dir: UP y=-SPEED, DOWN y=+SPEED, LEFT x=-SPEED, RIGHT x=+SPEED, NONE 0/0. Sign-extended to 10 bits.
  - move_pulse=1 iff new dir != NONE; otherwise 0.
  - step_x/step_y hold their values between ticks.
- A held key re-requests every Clk, so it never times out while held.

States:
- IDLE: dir NONE, no pending.
- MOVING: dir set, no pending.
- TURN_PEND: pending buffered.
- Transitions as defined above. STOPPED+pending and MOVING+pending both map to TURN_PEND; dir_out distinguishes them.

Decomposition:
- pacman_pkg: dir_t enum (NONE, UP, DOWN, LEFT, RIGHT, 3-bit), keycode constants, a dir_to_step function.
- Sub-module frame_tick_sync: 3-flop synchroniser plus rising-edge detector; reused by ball and redghost.

Test Plan:
- Reset=0 for 2 edges with keycode=8'h07 and a frame_clk pulse → all outputs 0/NONE; no move_pulse.
- Reset high, keycode=8'h07, all masks 0, frame_clk rises → move_pulse one Clk, 3 edges after first sample; dir_out=4, step_x=10'd1, step_y=0.
- Moving RIGHT with mapT=5'b00100, keycode=8'h1A pulsed for 1 Clk → pending_valid=1, pending_dir=1.
  - Next 3 ticks keep RIGHT.
  - Set mapT=0 → next tick dir_out=1, step_y=10'h3FF, pending_valid=0.
- Moving RIGHT, mapR set nonzero → next tick dir_out=0, steps 0, move_pulse stays 0.
- PEND_FRAMES=8, request UP blocked and never cleared → pending_valid drops on the 8th tick; dir unchanged.
- restart=1 in the same cycle as a tick with pending UP free → all cleared; no move_pulse afterward.
